// File: rtl/result_frame_serializer.sv
// Captures the nine operator-result nibbles on start and streams them out over
// valid/ready, followed by an XOR checksum nibble. All outputs are registered.
module result_frame_serializer #(
    parameter int W      = 4,
    parameter int NWORDS = 9,
    parameter int IDXW   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NWORDS*W-1:0]   res_bus,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDXW-1:0]       out_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_e;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
    localparam logic [IDXW-1:0] CSUM_IDX = IDXW'(NWORDS);

    state_e                state_q, state_d;
    logic [NWORDS*W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]          csum_q, csum_d;
    logic [IDXW-1:0]       idx_q, idx_d;

    logic [W-1:0]          data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [IDXW-1:0]       oidx_q, oidx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  xfer;
    logic [W-1:0]          sel_word;

    assign xfer = valid_q & out_ready;

    function automatic logic [W-1:0] xor_fold(input logic [NWORDS*W-1:0] b);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NWORDS; k++) acc ^= b[k*W +: W];
        return acc;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            csum_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            csum_q   <= csum_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        csum_d   = csum_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEND;
                    shadow_d = res_bus;
                    csum_d   = xor_fold(res_bus);
                    idx_d    = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) state_d = CSUM;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they appear registered with no
    // combinational path from out_ready/start.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NWORDS; k++)
            if (idx_d == IDXW'(k)) sel_word = shadow_d[k*W +: W];

        valid_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        last_d  = (state_d == CSUM);
        done_d  = (state_q == CSUM) && xfer;
        case (state_d)
            SEND:    begin data_d = sel_word; oidx_d = idx_d;    end
            CSUM:    begin data_d = csum_d;   oidx_d = CSUM_IDX; end
            default: begin data_d = '0;       oidx_d = '0;       end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            oidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            oidx_q  <= oidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_idx   = oidx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/result_frame_serializer.md
Name: result_frame_serializer

Overview:
- Reads the nine 4-bit operator-result buses produced by the combinational operator block (Arithmetic … Conditional).
- On a start pulse it snapshots them, then streams them out one nibble per transfer over a valid/ready interface.
- It appends a trailing XOR checksum nibble.
- It is the consuming/reading end of the operator block's result interface, feeding a bench monitor or a downstream UART/packer.

Parameters:
- W, 4, width of each result word and of out_data.
- NWORDS, 9, number of result words per frame (checksum word is extra).
- IDXW, 4, width of out_idx; must satisfy 2^IDXW > NWORDS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  frame request; sampled only in IDLE
- res_bus  input  NWORDS*W  packed results; word k = res_bus[k*W +: W]; k=0 Arithmetic, 1 Shift, 2 Relational, 3 Equality, 4 Bitwise, 5 Reduction, 6 Logical, 7 Concatenation, 8 Conditional
- out_data  output  W  current word
- out_valid  output  1  out_data/out_idx/out_last valid
- out_ready  input  1  sink accepts; transfer = out_valid & out_ready at a clk edge
- out_last  output  1  high only while the checksum word is presented
- out_idx  output  IDXW  index of presented word (0..NWORDS-1 data, NWORDS = checksum)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after the checksum transfer

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid, out_last, busy, done = 0; out_data=0; out_idx=0; shadow register and checksum accumulator cleared.
  - Takes effect immediately, mid-frame included; a partial frame is abandoned, not resumed.
- All outputs are registered; no combinational path from out_ready or start to any output.
- States:
  - IDLE: start=1 at an edge → capture res_bus into the shadow register, compute checksum = XOR of all NWORDS words, idx=0 → SEND. Next cycle out_valid=1, out_data=word0, busy=1. Start-to-first-valid latency is 1 clock.
  - SEND: presents word idx.
    - On transfer with idx<NWORDS-1: idx+1, next word presented the following cycle. No bubble, so one word per clock when out_ready is held 1.
    - On transfer with idx=NWORDS-1 → CSUM.
  - CSUM: out_data=checksum, out_idx=NWORDS, out_last=1. On transfer → IDLE: out_valid=0, out_last=0, busy=0, done=1 for exactly one cycle.
- Handshake rules:
  - Once out_valid=1, out_data, out_idx and out_last hold stable until the transfer.
  - out_valid never drops without a transfer, except on reset.
- start is ignored while busy=1; no queueing.
- start in the same cycle done=1 (state IDLE) is accepted, giving back-to-back frames with one idle cycle between.
- res_bus changes after capture do not affect the frame in flight.
- Full frame with out_ready=1 throughout: NWORDS+1 consecutive valid cycles; busy high for NWORDS+1 cycles.
- Checksum is a pure bitwise XOR; no carry, W bits wide.

Test Plan:
- Basic frame: res_bus words {1000,0001,0001,0001,0010,0001,0001,1011,1100} (operands A=1100, B=0110, C=0010, D=1100), start 1 cycle, out_ready=1.
  - Output sequence: 1000,0001,0001,0001,0010,0001,0001,1011,1100, then checksum 1100 with out_last=1, out_idx=9.
  - Frame spans 10 consecutive cycles; done pulses one cycle later.
- Backpressure: same frame, out_ready toggling 1,0,0,1,…
  - out_data/out_idx frozen during ready=0; same 10-word sequence, no duplicates, no drops.
- Snapshot: change res_bus to all 1111 one cycle after start.
  - Frame still emits the original words and checksum 1100.
- Busy/start: pulse start at word 4 → ignored, single frame.
  - start asserted in the done cycle → second frame begins one cycle later with out_idx=0.
- Reset mid-frame: rst_n=0 while out_idx=5 (async, between edges).
  - out_valid, busy, out_last go 0 immediately; after release, no output until a new start; the new frame starts at idx 0.
- All-zero res_bus → ten words of 0000, checksum 0000, out_last only on the tenth.
